// File: rtl/prgm_sequencer.sv
// Command-driven initiator for the FPGAComputer programming interface: turns
// write / execute-read commands into timed SEL/PRGM_IN/OP/PRGM/OE sequences.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | CMD_READY high, waiting for a command handshake
// SETUP  | SEL/PRGM_IN/OP driven, PRGM and OE low
// STROBE | PRGM high (write)
// HOLD   | PRGM low again, SEL/PRGM_IN still stable (write)
// SETTLE | OE high, BUS_OUT captured on the last cycle (read)
// RESP   | RSP_VALID high with captured data, waiting for RSP_READY
module prgm_sequencer #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 1,
  parameter int HOLD_CYC   = 1,
  parameter int SETTLE_CYC = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic       CMD_KIND,
  input  logic [3:0] CMD_SEL,
  input  logic [7:0] CMD_DATA,
  input  logic [2:0] CMD_OP,
  output logic       RSP_VALID,
  input  logic       RSP_READY,
  output logic [7:0] RSP_DATA,
  output logic [3:0] SEL,
  output logic [7:0] PRGM_IN,
  output logic [2:0] OP,
  output logic       PRGM,
  output logic       OE,
  input  logic [7:0] BUS_OUT,
  output logic       BUSY
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;
  localparam logic [2:0] ST_RESP   = 3'd5;

  // A phase length of zero is treated as one cycle.
  localparam logic [3:0] SETUP_LD  = (SETUP_CYC  < 1) ? 4'd1 : SETUP_CYC[3:0];
  localparam logic [3:0] STROBE_LD = (STROBE_CYC < 1) ? 4'd1 : STROBE_CYC[3:0];
  localparam logic [3:0] HOLD_LD   = (HOLD_CYC   < 1) ? 4'd1 : HOLD_CYC[3:0];
  localparam logic [3:0] SETTLE_LD = (SETTLE_CYC < 1) ? 4'd1 : SETTLE_CYC[3:0];

  logic [2:0] state;
  logic [3:0] cnt;
  logic       kind;
  logic       expired;

  assign expired = (cnt == 4'd1);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      kind      <= 1'b0;
      CMD_READY <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= 8'h00;
      SEL       <= 4'h0;
      PRGM_IN   <= 8'h00;
      OP        <= 3'd0;
      PRGM      <= 1'b0;
      OE        <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // CMD_READY comes up one edge after reset, so no command can be
          // taken on the release edge itself.
          if (!CMD_READY) begin
            CMD_READY <= 1'b1;
          end else if (CMD_VALID) begin
            SEL       <= CMD_SEL;
            OP        <= CMD_OP;
            kind      <= CMD_KIND;
            if (!CMD_KIND) PRGM_IN <= CMD_DATA;
            CMD_READY <= 1'b0;
            BUSY      <= 1'b1;
            cnt       <= SETUP_LD;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (expired) begin
            if (kind) begin
              OE    <= 1'b1;
              cnt   <= SETTLE_LD;
              state <= ST_SETTLE;
            end else begin
              PRGM  <= 1'b1;
              cnt   <= STROBE_LD;
              state <= ST_STROBE;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_STROBE: begin
          if (expired) begin
            PRGM  <= 1'b0;
            cnt   <= HOLD_LD;
            state <= ST_HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          if (expired) begin
            BUSY      <= 1'b0;
            CMD_READY <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_SETTLE: begin
          if (expired) begin
            RSP_DATA  <= BUS_OUT;
            RSP_VALID <= 1'b1;
            OE        <= 1'b0;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            BUSY      <= 1'b0;
            CMD_READY <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          PRGM      <= 1'b0;
          OE        <= 1'b0;
          RSP_VALID <= 1'b0;
          BUSY      <= 1'b0;
          CMD_READY <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
